// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access sequencer: funct3 codes, FSM
// encoding and the size/alignment helpers used at request acceptance.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] IR_DEFAULT = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } stateT;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } accSizeT;

  // Unsupported funct3 encodings fall back to a full-word access.
  function automatic accSizeT accessSize(input logic isWrite, input logic [2:0] funct3);
    accSizeT size;
    size = SZ_WORD;
    if (isWrite) begin
      if (funct3 == F3_SB) size = SZ_BYTE;
      else if (funct3 == F3_SH) size = SZ_HALF;
    end else begin
      if (funct3 == F3_LB || funct3 == F3_LBU) size = SZ_BYTE;
      else if (funct3 == F3_LH || funct3 == F3_LHU) size = SZ_HALF;
    end
    return size;
  endfunction

  function automatic logic isMisaligned(input accSizeT size, input logic [1:0] addrLo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addrLo[0];
      default: mis = |addrLo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_store_align.sv
// Byte-lane steering: store byte enables and replicated write data, and
// load extraction with sign/zero extension from the read word.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  iFunct3,
  input  logic [1:0]  iAddrLo,
  input  logic [31:0] iStoreData,
  input  logic [31:0] iRData,
  output logic [3:0]  oBe,
  output logic [31:0] oWData,
  output logic [31:0] oLoadData
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    oBe    = 4'b1111;
    oWData = iStoreData;
    case (iFunct3)
      F3_SB: begin
        oBe    = 4'b0001 << iAddrLo;
        oWData = {4{iStoreData[7:0]}};
      end
      F3_SH: begin
        oBe    = 4'b0011 << {iAddrLo[1], 1'b0};
        oWData = {2{iStoreData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (iAddrLo)
      2'd0:    byteVal = iRData[7:0];
      2'd1:    byteVal = iRData[15:8];
      2'd2:    byteVal = iRData[23:16];
      default: byteVal = iRData[31:24];
    endcase
    halfVal = iAddrLo[1] ? iRData[31:16] : iRData[15:0];
    case (iFunct3)
      F3_LB:   oLoadData = {{24{byteVal[7]}}, byteVal};
      F3_LBU:  oLoadData = {24'h0, byteVal};
      F3_LH:   oLoadData = {{16{halfVal[15]}}, halfVal};
      F3_LHU:  oLoadData = {16'h0, halfVal};
      default: oLoadData = iRData;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle req/ack sequencer between the control FSM and the single-port
// memory; fills IR/MDR, checks alignment and times out stalled transactions.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          MAX_WAIT = 255,
  parameter logic [31:0] IR_RESET = IR_DEFAULT
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic        iLoudD,
  input  logic        iWriteIR,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iPC,
  input  logic [31:0] iALUOut,
  input  logic [31:0] iStoreData,
  output logic [31:0] oBusAddr,
  output logic [31:0] oBusWData,
  output logic [3:0]  oBusBE,
  output logic        oBusReq,
  output logic        oBusWe,
  input  logic        iBusAck,
  input  logic [31:0] iBusRData,
  output logic [31:0] oIR,
  output logic [31:0] oMDR,
  output logic        oBusy,
  output logic        oDone,
  output logic        oMisaligned,
  output logic        oBusErr
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  stateT       state;
  logic [7:0]  waitCnt;
  logic [1:0]  addrLoQ;
  logic [2:0]  f3Q;
  logic        weQ;
  logic        writeIrQ;

  logic        reqValid;
  logic [31:0] reqAddr;
  logic        reqMis;
  logic        inBus;
  logic [2:0]  alignF3;
  logic [1:0]  alignAddrLo;
  logic [3:0]  alignBe;
  logic [31:0] alignWData;
  logic [31:0] alignLoad;

  assign reqValid = iMemRead | iMemWrite;
  assign reqAddr  = iLoudD ? iALUOut : iPC;
  assign reqMis   = isMisaligned(iLoudD ? accessSize(iMemWrite, iFunct3) : SZ_WORD,
                                 reqAddr[1:0]);
  assign inBus    = (state == BUS);
  assign oBusy    = inBus;

  // One aligner serves both phases: request fields at acceptance, latched fields at ack.
  assign alignF3     = inBus ? f3Q : iFunct3;
  assign alignAddrLo = inBus ? addrLoQ : reqAddr[1:0];

  load_store_align uAlign (
    .iFunct3    (alignF3),
    .iAddrLo    (alignAddrLo),
    .iStoreData (iStoreData),
    .iRData     (iBusRData),
    .oBe        (alignBe),
    .oWData     (alignWData),
    .oLoadData  (alignLoad)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      waitCnt     <= '0;
      addrLoQ     <= '0;
      f3Q         <= '0;
      weQ         <= 1'b0;
      writeIrQ    <= 1'b0;
      oBusAddr    <= '0;
      oBusWData   <= '0;
      oBusBE      <= '0;
      oBusReq     <= 1'b0;
      oBusWe      <= 1'b0;
      oIR         <= IR_RESET;
      oMDR        <= '0;
      oDone       <= 1'b0;
      oMisaligned <= 1'b0;
      oBusErr     <= 1'b0;
    end else begin
      oDone       <= 1'b0;
      oMisaligned <= 1'b0;
      oBusErr     <= 1'b0;
      case (state)
        BUS: begin
          if (iBusAck) begin
            if (!weQ) begin
              if (writeIrQ) oIR <= iBusRData;
              else          oMDR <= alignLoad;
            end
            oBusReq <= 1'b0;
            oBusWe  <= 1'b0;
            oDone   <= 1'b1;
            state   <= RESP;
          end else if (waitCnt == WAIT_LAST) begin
            oBusReq <= 1'b0;
            oBusWe  <= 1'b0;
            oBusErr <= 1'b1;
            oDone   <= 1'b1;
            state   <= RESP;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          if (reqValid) begin
            addrLoQ  <= reqAddr[1:0];
            f3Q      <= iFunct3;
            weQ      <= iMemWrite;
            writeIrQ <= iWriteIR;
            if (reqMis) begin
              oDone       <= 1'b1;
              oMisaligned <= 1'b1;
              state       <= RESP;
            end else begin
              oBusReq   <= 1'b1;
              oBusWe    <= iMemWrite;
              oBusAddr  <= {reqAddr[31:2], 2'b00};
              oBusBE    <= iMemWrite ? alignBe : 4'b1111;
              oBusWData <= alignWData;
              waitCnt   <= '0;
              state     <= BUS;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected completions are queued when a
// request is driven and checked when oDone fires.
module tb_mem_access_unit;

  localparam int MAXW = 4;

  logic        iClk = 1'b0;
  logic        iRst, iMemRead, iMemWrite, iLoudD, iWriteIR, iBusAck;
  logic [2:0]  iFunct3;
  logic [31:0] iPC, iALUOut, iStoreData, iBusRData;
  logic [31:0] oBusAddr, oBusWData, oIR, oMDR;
  logic [3:0]  oBusBE;
  logic        oBusReq, oBusWe, oBusy, oDone, oMisaligned, oBusErr;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        mis;
    logic        err;
  } expT;

  expT         sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] irModel, mdrModel;

  mem_access_unit #(.MAX_WAIT(MAXW), .IR_RESET(32'h00000013)) dut (
    .iClk(iClk), .iRst(iRst), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
    .iLoudD(iLoudD), .iWriteIR(iWriteIR), .iFunct3(iFunct3), .iPC(iPC),
    .iALUOut(iALUOut), .iStoreData(iStoreData), .oBusAddr(oBusAddr),
    .oBusWData(oBusWData), .oBusBE(oBusBE), .oBusReq(oBusReq), .oBusWe(oBusWe),
    .iBusAck(iBusAck), .iBusRData(iBusRData), .oIR(oIR), .oMDR(oMDR),
    .oBusy(oBusy), .oDone(oDone), .oMisaligned(oMisaligned), .oBusErr(oBusErr)
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (8 * lo);
    case (f3)
      3'b000: return {{24{sh[7]}}, sh[7:0]};
      3'b100: return {24'h0, sh[7:0]};
      3'b001: begin sh = d >> (16 * lo[1]); return {{16{sh[15]}}, sh[15:0]}; end
      3'b101: begin sh = d >> (16 * lo[1]); return {16'h0, sh[15:0]}; end
      default: return d;
    endcase
  endfunction

  // Drive a one-cycle request starting at the current negedge.
  task automatic drive(input logic rd, input logic wr, input logic loudD, input logic wir,
                       input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] sd);
    iMemRead = rd; iMemWrite = wr; iLoudD = loudD; iWriteIR = wir;
    iFunct3 = f3; iPC = pc; iALUOut = alu; iStoreData = sd;
    @(negedge iClk);
    iMemRead = 1'b0; iMemWrite = 1'b0;
  endtask

  task automatic ackAfter(input int waits, input logic [31:0] rdata);
    repeat (waits) @(negedge iClk);
    iBusAck = 1'b1; iBusRData = rdata;
    @(negedge iClk);
    iBusAck = 1'b0;
  endtask

  task automatic test_reset;
    iRst = 1'b1; iMemRead = 0; iMemWrite = 0; iLoudD = 0; iWriteIR = 0; iBusAck = 0;
    iFunct3 = 0; iPC = 0; iALUOut = 0; iStoreData = 0; iBusRData = 0;
    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    vectors++;
    if ({oBusReq, oBusWe, oBusBE, oBusAddr, oBusWData, oDone, oMisaligned, oBusErr, oBusy} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus: req=%b we=%b be=%h addr=%h wd=%h done=%b mis=%b err=%b busy=%b, expected all zero",
               oBusReq, oBusWe, oBusBE, oBusAddr, oBusWData, oDone, oMisaligned, oBusErr, oBusy);
    end
    vectors++;
    if (oIR !== 32'h00000013 || oMDR !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: ir=%h mdr=%h, expected ir=00000013 mdr=00000000", oIR, oMDR);
    end
    irModel = 32'h00000013; mdrModel = 32'h0;
  endtask

  task automatic test_fetch;
    expT e;
    sb.push_back('{ir: 32'h00500093, mdr: mdrModel, mis: 1'b0, err: 1'b0});
    irModel = 32'h00500093;
    drive(1, 0, 0, 1, 3'b010, 32'h100, 32'hDEAD_0000, 32'h0);
    vectors++;
    if ({oBusReq, oBusy, oBusWe, oBusBE, oBusAddr} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h100}) begin
      miscompares++;
      $display("FAIL fetch_bus: req=%b busy=%b we=%b be=%h addr=%h, expected 1 1 0 f 00000100",
               oBusReq, oBusy, oBusWe, oBusBE, oBusAddr);
    end
    ackAfter(0, 32'h00500093);
    e = sb.pop_front();
    vectors++;
    if ({oDone, oBusReq, oMisaligned, oBusErr, oIR, oMDR} !== {1'b1, 1'b0, e.mis, e.err, e.ir, e.mdr}) begin
      miscompares++;
      $display("FAIL fetch_done: done=%b req=%b mis=%b err=%b ir=%h mdr=%h, expected 1 0 %b %b %h %h",
               oDone, oBusReq, oMisaligned, oBusErr, oIR, oMDR, e.mis, e.err, e.ir, e.mdr);
    end
    @(negedge iClk);
    vectors++;
    if ({oDone, oIR} !== {1'b0, irModel}) begin
      miscompares++;
      $display("FAIL fetch_pulse: done=%b ir=%h, expected 0 %h", oDone, oIR, irModel);
    end
  endtask

  task automatic test_load;
    logic [2:0]  f3s   [6];
    logic [31:0] addrs [6];
    logic [31:0] dats  [6];
    int          waits [6];
    expT         e;
    f3s   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110};
    addrs = '{32'h203, 32'h203, 32'h202, 32'h200, 32'h200, 32'h204};
    dats  = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h7FFF8001, 32'h80FF1234, 32'h12345678};
    waits = '{0, 1, 2, 0, 3, 1};
    for (int i = 0; i < 6; i++) begin
      mdrModel = modelLoad(f3s[i], addrs[i][1:0], dats[i]);
      sb.push_back('{ir: irModel, mdr: mdrModel, mis: 1'b0, err: 1'b0});
      drive(1, 0, 1, 0, f3s[i], 32'h0, addrs[i], 32'h0);
      vectors++;
      if ({oBusReq, oBusWe, oBusBE, oBusAddr} !== {1'b1, 1'b0, 4'hF, addrs[i] & 32'hFFFF_FFFC}) begin
        miscompares++;
        $display("FAIL load_bus[%0d]: req=%b we=%b be=%h addr=%h, expected 1 0 f %h",
                 i, oBusReq, oBusWe, oBusBE, oBusAddr, addrs[i] & 32'hFFFF_FFFC);
      end
      ackAfter(waits[i], dats[i]);
      e = sb.pop_front();
      vectors++;
      if ({oDone, oMisaligned, oBusErr, oIR, oMDR} !== {1'b1, e.mis, e.err, e.ir, e.mdr}) begin
        miscompares++;
        $display("FAIL load_done[%0d]: done=%b mis=%b err=%b ir=%h mdr=%h, expected 1 %b %b %h %h",
                 i, oDone, oMisaligned, oBusErr, oIR, oMDR, e.mis, e.err, e.ir, e.mdr);
      end
    end
    @(negedge iClk);
  endtask

  task automatic test_store;
    logic [2:0]  f3s   [4];
    logic [31:0] addrs [4];
    logic [3:0]  bes   [4];
    logic [31:0] wds   [4];
    int          waits [4];
    expT         e;
    f3s   = '{3'b001, 3'b000, 3'b010, 3'b111};
    addrs = '{32'h206, 32'h201, 32'h204, 32'h208};
    bes   = '{4'b1100, 4'b0010, 4'b1111, 4'b1111};
    wds   = '{32'hBEEFBEEF, 32'hEFEFEFEF, 32'hDEADBEEF, 32'hDEADBEEF};
    waits = '{2, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{ir: irModel, mdr: mdrModel, mis: 1'b0, err: 1'b0});
      drive(0, 1, 1, 0, f3s[i], 32'h0, addrs[i], 32'hDEADBEEF);
      iStoreData = 32'h0; iALUOut = 32'hFFFF_FFFF;
      for (int w = 0; w <= waits[i]; w++) begin
        vectors++;
        if ({oBusReq, oBusWe, oBusBE, oBusAddr, oBusWData} !==
            {1'b1, 1'b1, bes[i], addrs[i] & 32'hFFFF_FFFC, wds[i]}) begin
          miscompares++;
          $display("FAIL store_bus[%0d.%0d]: req=%b we=%b be=%b addr=%h wd=%h, expected 1 1 %b %h %h",
                   i, w, oBusReq, oBusWe, oBusBE, oBusAddr, oBusWData, bes[i],
                   addrs[i] & 32'hFFFF_FFFC, wds[i]);
        end
        if (w < waits[i]) @(negedge iClk);
      end
      ackAfter(0, 32'h5555_5555);
      e = sb.pop_front();
      vectors++;
      if ({oDone, oBusReq, oBusWe, oIR, oMDR} !== {1'b1, 1'b0, 1'b0, e.ir, e.mdr}) begin
        miscompares++;
        $display("FAIL store_done[%0d]: done=%b req=%b we=%b ir=%h mdr=%h, expected 1 0 0 %h %h",
                 i, oDone, oBusReq, oBusWe, oIR, oMDR, e.ir, e.mdr);
      end
    end
    @(negedge iClk);
  endtask

  task automatic test_misaligned;
    logic        wrs   [4];
    logic        lds   [4];
    logic [2:0]  f3s   [4];
    logic [31:0] addrs [4];
    expT         e;
    wrs   = '{1'b0, 1'b0, 1'b1, 1'b0};
    lds   = '{1'b1, 1'b1, 1'b1, 1'b0};
    f3s   = '{3'b010, 3'b101, 3'b001, 3'b000};
    addrs = '{32'h202, 32'h203, 32'h207, 32'h102};
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{ir: irModel, mdr: mdrModel, mis: 1'b1, err: 1'b0});
      drive(!wrs[i], wrs[i], lds[i], !lds[i], f3s[i], addrs[i], addrs[i], 32'h1234_5678);
      e = sb.pop_front();
      vectors++;
      if ({oDone, oMisaligned, oBusErr, oBusReq, oIR, oMDR} !== {1'b1, e.mis, e.err, 1'b0, e.ir, e.mdr}) begin
        miscompares++;
        $display("FAIL misaligned[%0d]: done=%b mis=%b err=%b req=%b ir=%h mdr=%h, expected 1 1 0 0 %h %h",
                 i, oDone, oMisaligned, oBusErr, oBusReq, oIR, oMDR, e.ir, e.mdr);
      end
    end
    @(negedge iClk);
  endtask

  task automatic test_timeout;
    int  n;
    expT e;
    sb.push_back('{ir: irModel, mdr: mdrModel, mis: 1'b0, err: 1'b1});
    drive(1, 0, 1, 0, 3'b010, 32'h0, 32'h208, 32'h0);
    n = 0;
    while (oBusReq === 1'b1 && n < 20) begin
      n++;
      @(negedge iClk);
    end
    vectors++;
    if (n != MAXW) begin
      miscompares++;
      $display("FAIL timeout_req_cycles: got %0d cycles of req, expected %0d", n, MAXW);
    end
    e = sb.pop_front();
    vectors++;
    if ({oDone, oBusErr, oMisaligned, oIR, oMDR} !== {1'b1, e.err, e.mis, e.ir, e.mdr}) begin
      miscompares++;
      $display("FAIL timeout_done: done=%b err=%b mis=%b ir=%h mdr=%h, expected 1 1 0 %h %h",
               oDone, oBusErr, oMisaligned, oIR, oMDR, e.ir, e.mdr);
    end
    ackAfter(0, 32'hA5A5_A5A5);
    vectors++;
    if ({oDone, oBusErr, oMDR} !== {1'b0, 1'b0, mdrModel}) begin
      miscompares++;
      $display("FAIL timeout_late_ack: done=%b err=%b mdr=%h, expected 0 0 %h", oDone, oBusErr, oMDR, mdrModel);
    end
  endtask

  task automatic test_back_to_back;
    expT e;
    mdrModel = 32'h0BAD_F00D;
    sb.push_back('{ir: irModel, mdr: mdrModel, mis: 1'b0, err: 1'b0});
    drive(1, 0, 1, 0, 3'b010, 32'h0, 32'h20C, 32'h0);
    ackAfter(0, 32'h0BAD_F00D);
    e = sb.pop_front();
    vectors++;
    if ({oDone, oMDR} !== {1'b1, e.mdr}) begin
      miscompares++;
      $display("FAIL b2b_load: done=%b mdr=%h, expected 1 %h", oDone, oMDR, e.mdr);
    end
    // Issued during RESP, both read and write asserted: the write must win.
    sb.push_back('{ir: irModel, mdr: mdrModel, mis: 1'b0, err: 1'b0});
    drive(1, 1, 1, 0, 3'b000, 32'h0, 32'h20D, 32'h0000_00A5);
    vectors++;
    if ({oBusReq, oBusWe, oBusBE, oBusAddr, oBusWData} !== {1'b1, 1'b1, 4'b0010, 32'h20C, 32'hA5A5A5A5}) begin
      miscompares++;
      $display("FAIL b2b_store_bus: req=%b we=%b be=%b addr=%h wd=%h, expected 1 1 0010 0000020c a5a5a5a5",
               oBusReq, oBusWe, oBusBE, oBusAddr, oBusWData);
    end
    ackAfter(1, 32'hFFFF_FFFF);
    e = sb.pop_front();
    vectors++;
    if ({oDone, oIR, oMDR} !== {1'b1, e.ir, e.mdr}) begin
      miscompares++;
      $display("FAIL b2b_store_done: done=%b ir=%h mdr=%h, expected 1 %h %h", oDone, oIR, oMDR, e.ir, e.mdr);
    end
    irModel = 32'h00A00113;
    sb.push_back('{ir: irModel, mdr: mdrModel, mis: 1'b0, err: 1'b0});
    drive(1, 0, 0, 1, 3'b000, 32'h300, 32'h0, 32'h0);
    ackAfter(0, 32'h00A00113);
    e = sb.pop_front();
    vectors++;
    if ({oDone, oIR, oMDR} !== {1'b1, e.ir, e.mdr}) begin
      miscompares++;
      $display("FAIL b2b_fetch: done=%b ir=%h mdr=%h, expected 1 %h %h", oDone, oIR, oMDR, e.ir, e.mdr);
    end
    @(negedge iClk);
  endtask

  task automatic test_reset_mid;
    drive(1, 0, 1, 0, 3'b010, 32'h0, 32'h210, 32'h0);
    @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    irModel = 32'h00000013; mdrModel = 32'h0;
    vectors++;
    if ({oBusReq, oBusy, oDone, oIR, oMDR} !== {1'b0, 1'b0, 1'b0, irModel, mdrModel}) begin
      miscompares++;
      $display("FAIL reset_mid: req=%b busy=%b done=%b ir=%h mdr=%h, expected 0 0 0 %h %h",
               oBusReq, oBusy, oDone, oIR, oMDR, irModel, mdrModel);
    end
    ackAfter(0, 32'hCAFE_F00D);
    vectors++;
    if ({oBusReq, oDone, oIR, oMDR} !== {1'b0, 1'b0, irModel, mdrModel}) begin
      miscompares++;
      $display("FAIL reset_stray_ack: req=%b done=%b ir=%h mdr=%h, expected 0 0 %h %h",
               oBusReq, oDone, oIR, oMDR, irModel, mdrModel);
    end
  endtask

  initial begin
    @(negedge iClk);
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
